// File: rtl/sr_pulse_driver.sv
// Push-button front end for an active-low SR latch: synchronise and debounce two buttons,
// then turn debounced presses into fixed-width, mutually exclusive notS/notR pulses.
module sr_pulse_driver #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned PULSE_CYCLES    = 4,
   parameter int unsigned CNT_W           = 8
) (
   input  logic Clock,
   input  logic nReset,
   input  logic SetButton,
   input  logic ResetButton,
   output logic notS,
   output logic notR,
   output logic Busy,
   output logic Conflict
);

   localparam logic [CNT_W-1:0] DebLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] PulseLast = CNT_W'(PULSE_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StPulseS, StPulseR, StGap} state_e;

   // Channel 0 is the set button, channel 1 the reset button.
   logic [1:0]       w_raw;
   logic [1:0]       r_sync1;
   logic [1:0]       r_sync2;
   logic [1:0]       r_deb;
   logic [1:0]       r_deb_prev;
   logic [1:0]       r_req;
   logic [CNT_W-1:0] r_deb_cnt [2];

   state_e           r_state;
   state_e           w_state_d;
   logic [CNT_W-1:0] r_pcnt;
   logic [CNT_W-1:0] w_pcnt_d;
   logic             r_pend_s;
   logic             r_pend_r;
   logic             w_pend_s_d;
   logic             w_pend_r_d;
   logic             w_want_s;
   logic             w_want_r;
   logic             w_conflict;

   logic             w_nots_d;
   logic             w_notr_d;
   logic             w_busy_d;
   logic             r_nots;
   logic             r_notr;
   logic             r_busy;
   logic             r_conflict;

   assign w_raw = {ResetButton, SetButton};

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_deb      <= '0;
         r_deb_prev <= '0;
         r_req      <= '0;
         for (int i = 0; i < 2; i++) begin
            r_deb_cnt[i] <= '0;
         end
      end else begin
         r_sync1    <= w_raw;
         r_sync2    <= r_sync1;
         r_deb_prev <= r_deb;
         // Only a debounced rising edge is a request; releases are ignored.
         r_req      <= r_deb & ~r_deb_prev;
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_deb_cnt[i] <= '0;
            end else if (r_deb_cnt[i] == DebLast) begin
               r_deb[i]     <= r_sync2[i];
               r_deb_cnt[i] <= '0;
            end else begin
               r_deb_cnt[i] <= r_deb_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // FSM state register
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_state  <= StIdle;
         r_pcnt   <= '0;
         r_pend_s <= 1'b0;
         r_pend_r <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_pcnt   <= w_pcnt_d;
         r_pend_s <= w_pend_s_d;
         r_pend_r <= w_pend_r_d;
      end
   end

   assign w_want_s = r_req[0] | r_pend_s;
   assign w_want_r = r_req[1] | r_pend_r;

   // FSM next state; GAP exits through the same arbitration as IDLE so a queued request
   // starts its pulse right after the single gap cycle.
   always_comb begin
      w_state_d  = r_state;
      w_pcnt_d   = r_pcnt;
      w_pend_s_d = r_pend_s;
      w_pend_r_d = r_pend_r;
      w_conflict = 1'b0;
      unique case (r_state)
         StIdle, StGap: begin
            w_pcnt_d   = '0;
            w_pend_s_d = 1'b0;
            w_pend_r_d = 1'b0;
            if (w_want_s && w_want_r) begin
               w_conflict = 1'b1;
               w_state_d  = StIdle;
            end else if (w_want_s) begin
               w_state_d = StPulseS;
            end else if (w_want_r) begin
               w_state_d = StPulseR;
            end else begin
               w_state_d = StIdle;
            end
         end
         StPulseS, StPulseR: begin
            w_pend_s_d = r_pend_s | r_req[0];
            w_pend_r_d = r_pend_r | r_req[1];
            if (r_pcnt == PulseLast) begin
               w_pcnt_d  = '0;
               w_state_d = StGap;
            end else begin
               w_pcnt_d = r_pcnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   // FSM outputs, decoded from the next state so they register alongside it
   always_comb begin
      w_nots_d = (w_state_d != StPulseS);
      w_notr_d = (w_state_d != StPulseR);
      w_busy_d = (w_state_d != StIdle);
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_nots     <= 1'b1;
         r_notr     <= 1'b1;
         r_busy     <= 1'b0;
         r_conflict <= 1'b0;
      end else begin
         r_nots     <= w_nots_d;
         r_notr     <= w_notr_d;
         r_busy     <= w_busy_d;
         r_conflict <= w_conflict;
      end
   end

   assign notS     = r_nots;
   assign notR     = r_notr;
   assign Busy     = r_busy;
   assign Conflict = r_conflict;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed bench for sr_pulse_driver driving an active-low SR latch model.
// Edge k is the k-th rising clock edge after an input change made just before it.
module tb_sr_pulse_driver;

   logic Clock;
   logic nReset;
   logic SetButton;
   logic ResetButton;
   logic notS;
   logic notR;
   logic Busy;
   logic Conflict;
   logic r_q;

   int   n_cmp;
   int   n_bad;

   sr_pulse_driver #(
      .DEBOUNCE_CYCLES(16),
      .PULSE_CYCLES   (4),
      .CNT_W          (8)
   ) u_dut (
      .Clock      (Clock),
      .nReset     (nReset),
      .SetButton  (SetButton),
      .ResetButton(ResetButton),
      .notS       (notS),
      .notR       (notR),
      .Busy       (Busy),
      .Conflict   (Conflict)
   );

   // The load: rs_flipflop latch, notS has priority.
   always_latch begin
      if (!notS) begin
         r_q = 1'b1;
      end else if (!notR) begin
         r_q = 1'b0;
      end
   end

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check_bit(input string tag, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b", tag, got, exp);
      end
   endtask

   // Wait for edge k, then check all outputs and the never-both-low invariant at the negedge.
   task automatic edge_check(input string tag, input int k, input logic es, input logic er,
                             input logic eb, input logic ec);
      string t;
      @(posedge Clock);
      @(negedge Clock);
      t = $sformatf("%s[%0d]", tag, k);
      check_bit({t, ".notS"}, notS, es);
      check_bit({t, ".notR"}, notR, er);
      check_bit({t, ".Busy"}, Busy, eb);
      check_bit({t, ".Conflict"}, Conflict, ec);
      check_bit({t, ".inv"}, notS | notR, 1'b1);
   endtask

   task automatic idle_run(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         edge_check(tag, k, 1'b1, 1'b1, 1'b0, 1'b0);
      end
   endtask

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      nReset      = 1'b0;
      SetButton   = 1'b1;
      ResetButton = 1'b1;

      // 1: reset values, then quiet after release
      repeat (3) @(negedge Clock);
      check_bit("rst.notS", notS, 1'b1);
      check_bit("rst.notR", notR, 1'b1);
      check_bit("rst.Busy", Busy, 1'b0);
      check_bit("rst.Conflict", Conflict, 1'b0);
      SetButton   = 1'b0;
      ResetButton = 1'b0;
      nReset      = 1'b1;
      idle_run("quiet", 100);

      // 2: clean set press, pulse at edges 19..22, busy 19..23
      for (int k = 0; k < 40; k++) begin
         SetButton = 1'b1;
         edge_check("set", k, !(k >= 19 && k <= 22), 1'b1, (k >= 19 && k <= 23), 1'b0);
      end
      check_bit("set.Q", r_q, 1'b1);
      SetButton = 1'b0;
      idle_run("set_rel", 40);

      // 4: simultaneous press is dropped with a one-cycle conflict strobe
      for (int k = 0; k < 40; k++) begin
         SetButton   = 1'b1;
         ResetButton = 1'b1;
         edge_check("both", k, 1'b1, 1'b1, 1'b0, (k == 19));
      end
      check_bit("both.Q", r_q, 1'b1);
      SetButton   = 1'b0;
      ResetButton = 1'b0;
      idle_run("both_rel", 40);

      // 5: reset request lands in the 2nd set-pulse cycle and is queued behind it
      for (int k = 0; k < 45; k++) begin
         SetButton = 1'b1;
         if (k >= 2) ResetButton = 1'b1;
         edge_check("queue", k, !(k >= 19 && k <= 22), !(k >= 24 && k <= 27),
                    (k >= 19 && k <= 28), 1'b0);
         if (k == 23) check_bit("queue.Q_set", r_q, 1'b1);
      end
      check_bit("queue.Q_rst", r_q, 1'b0);
      SetButton   = 1'b0;
      ResetButton = 1'b0;
      idle_run("queue_rel", 40);

      // 3a: bounce (5 high / 3 low for 20 cycles) then low -> nothing
      for (int k = 0; k < 80; k++) begin
         SetButton = (k < 20) && ((k % 8) < 5);
         edge_check("bounce_lo", k, 1'b1, 1'b1, 1'b0, 1'b0);
      end
      check_bit("bounce_lo.Q", r_q, 1'b0);

      // 3b: same bounce ending in a steady high from cycle 16 -> one pulse at 16+19
      for (int k = 0; k < 60; k++) begin
         SetButton = (k >= 16) || ((k % 8) < 5);
         edge_check("bounce_hi", k, !(k >= 35 && k <= 38), 1'b1, (k >= 35 && k <= 39), 1'b0);
      end
      check_bit("bounce_hi.Q", r_q, 1'b1);
      SetButton = 1'b0;
      idle_run("bounce_rel", 40);

      // 6: asynchronous reset in the 2nd low cycle of a set pulse
      for (int k = 0; k <= 20; k++) begin
         SetButton = 1'b1;
         edge_check("midrst", k, !(k >= 19), 1'b1, (k >= 19), 1'b0);
      end
      nReset    = 1'b0;
      SetButton = 1'b0;
      #1;
      check_bit("midrst.async_notS", notS, 1'b1);
      check_bit("midrst.async_notR", notR, 1'b1);
      check_bit("midrst.async_Busy", Busy, 1'b0);
      repeat (2) @(negedge Clock);
      nReset = 1'b1;
      idle_run("midrst_rel", 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
